// File: rtl/timer_down_26bit_if.sv
// timer_down_26bit_if
//   Control/status bundle for the loadable down-counting timer.
//   The clock and the reset are not part of this bundle.
//   master : drives En, Load, Auto and D; observes Q, Tick, Busy and Done.
//   slave  : the timer itself.
//   Signals:
//     En   - count enable, honoured only while running
//     Load - load strobe; captures D and Auto
//     Auto - 1 = auto-reload, 0 = one-shot (sampled only with Load)
//     D    - load value, in En-qualified cycles per period
//     Q    - current count
//     Tick - one-cycle terminal-count strobe
//     Busy - high while running
//     Done - high once a one-shot has expired
interface timer_down_26bit_if #(
    parameter int WIDTH = 26
);
    logic             En;
    logic             Load;
    logic             Auto;
    logic [WIDTH-1:0] D;
    logic [WIDTH-1:0] Q;
    logic             Tick;
    logic             Busy;
    logic             Done;

    modport master (
        output En, Load, Auto, D,
        input  Q, Tick, Busy, Done
    );

    modport slave (
        input  En, Load, Auto, D,
        output Q, Tick, Busy, Done
    );
endinterface

// File: rtl/timer_down_26bit.sv
// timer_down_26bit
//   Loadable down-counting timer. It turns a loaded cycle count into a
//   registered one-cycle Tick strobe. It can run one-shot or auto-reload.
//   Ports:
//     Clk - system clock; all state changes on the rising edge
//     Clr - synchronous active-low reset
//     bus - timer_down_26bit_if.slave (En, Load, Auto, D in; Q, Tick,
//           Busy, Done out)
//   All outputs come straight from flops. No input reaches an output
//   combinationally.
module timer_down_26bit #(
    parameter int WIDTH = 26
) (
    input  logic                Clk,
    input  logic                Clr,
    timer_down_26bit_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
    localparam logic [WIDTH-1:0] ZERO = '0;

    state_t           state;
    logic [WIDTH-1:0] q;        // current count
    logic [WIDTH-1:0] r;        // reload value captured at Load
    logic             m;        // 1 = auto-reload mode
    logic             tick;
    logic             busy;
    logic             done;

    // One registered FSM. Precedence is Clr, then Load, then the state action.
    // Busy and Done are registered copies of the next state. This keeps them
    // in step with Q and Tick.
    always_ff @(posedge Clk) begin
        if (!Clr) begin
            state <= IDLE;
            q     <= ZERO;
            r     <= ZERO;
            m     <= 1'b0;
            tick  <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else if (bus.Load) begin
            // Load wins over a terminal edge on the same cycle. Any Tick that
            // edge would have produced is dropped.
            q    <= bus.D;
            r    <= bus.D;
            m    <= bus.Auto;
            tick <= 1'b0;
            done <= 1'b0;
            if (bus.D != ZERO) begin
                state <= RUN;
                busy  <= 1'b1;
            end else begin
                // A zero load parks the timer, so no Tick can ever follow.
                state <= IDLE;
                busy  <= 1'b0;
            end
        end else begin
            tick <= 1'b0;
            case (state)
                IDLE: begin
                    busy <= 1'b0;
                    done <= 1'b0;
                end
                RUN: begin
                    busy <= 1'b1;
                    done <= 1'b0;
                    if (bus.En) begin
                        if (q == ONE) begin
                            tick <= 1'b1;
                            if (m) begin
                                // The reload happens on the terminal edge
                                // itself. The period is therefore exactly R
                                // enabled cycles, with no dead cycle.
                                q <= r;
                            end else begin
                                q     <= ZERO;
                                state <= DONE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end
                        end else if (q != ZERO) begin
                            // The guard stops any wrap if Q were ever 0 in RUN.
                            q <= q - ONE;
                        end
                    end
                end
                DONE: begin
                    q    <= ZERO;
                    busy <= 1'b0;
                    done <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.Q    = q;
    assign bus.Tick = tick;
    assign bus.Busy = busy;
    assign bus.Done = done;

endmodule

// File: tb/tb_timer_down_26bit.sv
module tb_timer_down_26bit;

    localparam int W = 26;

    logic clk = 1'b0;
    logic clr;

    timer_down_26bit_if #(.WIDTH(W)) bus ();

    timer_down_26bit #(.WIDTH(W)) dut (
        .Clk (clk),
        .Clr (clr),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] q;
        logic         tick;
        logic         busy;
        logic         done;
        string        name;
    } exp_t;

    exp_t exp_q[$];
    int   compared   = 0;
    int   mismatched = 0;

    // Drives one cycle of inputs on the falling edge. It also queues what the
    // outputs must be after the next rising edge.
    task automatic cyc(input logic clr_v, input logic en_v, input logic load_v,
                       input logic auto_v, input logic [W-1:0] d_v,
                       input logic [W-1:0] q_e, input logic t_e,
                       input logic b_e, input logic dn_e, input string nm);
        exp_t e;
        @(negedge clk);
        clr      = clr_v;
        bus.En   = en_v;
        bus.Load = load_v;
        bus.Auto = auto_v;
        bus.D    = d_v;
        e.q = q_e; e.tick = t_e; e.busy = b_e; e.done = dn_e; e.name = nm;
        exp_q.push_back(e);
    endtask

    // Monitor: one queued expectation per rising edge, checked 1 ns later.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                compared++;
                if ({bus.Q, bus.Tick, bus.Busy, bus.Done} !==
                    {e.q, e.tick, e.busy, e.done}) begin
                    mismatched++;
                    $display("FAIL %s: got Q=%0d Tick=%b Busy=%b Done=%b, want Q=%0d Tick=%b Busy=%b Done=%b",
                             e.name, bus.Q, bus.Tick, bus.Busy, bus.Done,
                             e.q, e.tick, e.busy, e.done);
                end
            end
        end
    end

    initial begin
        clr = 1'b0; bus.En = 1'b0; bus.Load = 1'b0; bus.Auto = 1'b0; bus.D = '0;

        // power-up reset
        cyc(0, 0, 0, 0, 0,   0, 0, 0, 0, "por0");
        cyc(0, 0, 0, 0, 0,   0, 0, 0, 0, "por1");

        // 1. reset mid-count
        cyc(1, 0, 1, 0, 6,   6, 0, 1, 0, "rst_load6");
        cyc(1, 1, 0, 0, 0,   5, 0, 1, 0, "rst_cnt5");
        cyc(0, 1, 0, 0, 0,   0, 0, 0, 0, "rst_mid0");
        cyc(0, 1, 0, 0, 0,   0, 0, 0, 0, "rst_mid1");
        cyc(1, 1, 0, 0, 0,   0, 0, 0, 0, "rst_idle_en0");
        cyc(1, 1, 0, 0, 0,   0, 0, 0, 0, "rst_idle_en1");

        // 2. one-shot D=3
        cyc(1, 0, 1, 0, 3,   3, 0, 1, 0, "os_load");
        cyc(1, 1, 0, 0, 0,   2, 0, 1, 0, "os_q2");
        cyc(1, 1, 0, 0, 0,   1, 0, 1, 0, "os_q1");
        cyc(1, 1, 0, 0, 0,   0, 1, 0, 1, "os_term");
        cyc(1, 1, 0, 0, 0,   0, 0, 0, 1, "os_hold0");
        cyc(1, 1, 0, 1, 0,   0, 0, 0, 1, "os_hold1");

        // 3. auto-reload D=4 (from DONE); Auto toggled outside Load
        cyc(1, 0, 1, 1, 4,   4, 0, 1, 0, "ar_load");
        for (int i = 1; i <= 11; i++)
            cyc(1, 1, 0, i[0], 0, W'(4 - (i % 4)), (i % 4) == 0, 1, 0, "ar_run");

        // 4. pause pattern, D=5 one-shot
        cyc(1, 0, 1, 0, 5,   5, 0, 1, 0, "pz_load");
        cyc(1, 1, 0, 0, 0,   4, 0, 1, 0, "pz_4");
        cyc(1, 0, 0, 0, 0,   4, 0, 1, 0, "pz_hold0");
        cyc(1, 0, 0, 0, 0,   4, 0, 1, 0, "pz_hold1");
        cyc(1, 1, 0, 0, 0,   3, 0, 1, 0, "pz_3");
        cyc(1, 1, 0, 0, 0,   2, 0, 1, 0, "pz_2");
        cyc(1, 1, 0, 0, 0,   1, 0, 1, 0, "pz_1");
        cyc(1, 1, 0, 0, 0,   0, 1, 0, 1, "pz_term");

        // 5. load on terminal edge, then zero load
        cyc(1, 0, 1, 1, 2,   2, 0, 1, 0, "col_load2");
        cyc(1, 1, 0, 1, 0,   1, 0, 1, 0, "col_q1");
        cyc(1, 1, 1, 1, 7,   7, 0, 1, 0, "col_load7");
        cyc(1, 0, 0, 0, 0,   7, 0, 1, 0, "col_hold");
        cyc(1, 1, 1, 1, 0,   0, 0, 0, 0, "zero_load");
        cyc(1, 1, 0, 1, 0,   0, 0, 0, 0, "zero_idle0");
        cyc(1, 1, 0, 1, 0,   0, 0, 0, 0, "zero_idle1");
        cyc(1, 1, 0, 1, 0,   0, 0, 0, 0, "zero_idle2");

        // R=1 auto: Tick every enabled cycle
        cyc(1, 0, 1, 1, 1,   1, 0, 1, 0, "r1_load");
        cyc(1, 1, 0, 0, 0,   1, 1, 1, 0, "r1_t0");
        cyc(1, 1, 0, 0, 0,   1, 1, 1, 0, "r1_t1");
        cyc(1, 0, 0, 0, 0,   1, 0, 1, 0, "r1_pause");

        // 6. full width
        cyc(1, 0, 1, 0, 26'd67108863,  26'd67108863, 0, 1, 0, "fw_load");
        cyc(1, 1, 0, 0, 0,             26'd67108862, 0, 1, 0, "fw_dec");
        cyc(1, 1, 1, 0, 2,             2, 0, 1, 0, "fw_reload2");
        cyc(1, 1, 0, 0, 0,             1, 0, 1, 0, "fw_q1");
        cyc(1, 1, 0, 0, 0,             0, 1, 0, 1, "fw_term");
        for (int i = 0; i < 10; i++)
            cyc(1, 1, 0, 0, 0,         0, 0, 0, 1, "fw_nowrap");

        // drain the scoreboard, bounded
        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge clk);
        #2;
        if (exp_q.size() > 0) begin
            mismatched++;
            $display("FAIL drain: got %0d entries left, want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
